// File: rtl/alu_pkg.sv
// Shared op codes, FSM state type and op classification for the sequenced ALU.
package alu_pkg;

   localparam logic [3:0] ALU_AND   = 4'b0000;
   localparam logic [3:0] ALU_OR    = 4'b0001;
   localparam logic [3:0] ALU_ADD   = 4'b0010;
   localparam logic [3:0] ALU_SLL   = 4'b0011;
   localparam logic [3:0] ALU_SLT   = 4'b0100;
   localparam logic [3:0] ALU_SLTU  = 4'b0101;
   localparam logic [3:0] ALU_SUB   = 4'b0110;
   localparam logic [3:0] ALU_XOR   = 4'b0111;
   localparam logic [3:0] ALU_SRL   = 4'b1000;
   localparam logic [3:0] ALU_MUL   = 4'b1001;
   localparam logic [3:0] ALU_SRA   = 4'b1010;
   localparam logic [3:0] ALU_MULHU = 4'b1011;
   localparam logic [3:0] ALU_DIVU  = 4'b1100;
   localparam logic [3:0] ALU_REMU  = 4'b1101;
   localparam logic [3:0] ALU_DIV   = 4'b1110;
   localparam logic [3:0] ALU_REM   = 4'b1111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ONE  = 2'd1,
      ITER = 2'd2,
      DONE = 2'd3
   } state_t;

   function automatic logic is_iter(input logic [3:0] op);
      return (op == ALU_MUL) || (op == ALU_MULHU) || (op[3:2] == 2'b11);
   endfunction

endpackage

// File: rtl/alu_iter_core.sv
// Iterative multiply (shift-add) and divide (restoring) engine; one bit per cycle,
// the final step's result is presented combinationally on o_result while o_last is high.
module alu_iter_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_flush,
   input  logic             i_start,
   input  logic [3:0]       i_op,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_last,
   output logic [WIDTH-1:0] o_result
);

   localparam int SHW = $clog2(WIDTH);
   localparam logic [SHW:0] LAST_CNT = (SHW+1)'(WIDTH-1);

   logic             r_run, r_neg_q, r_neg_r, r_dz;
   logic [SHW:0]     r_cnt;
   logic [3:0]       r_op;
   logic [WIDTH-1:0] r_hi, r_lo, r_d;

   logic             w_is_mul, w_signed, w_a_neg, w_b_neg, w_qbit;
   logic [WIDTH-1:0] w_a_mag, w_b_mag, w_hi_n, w_lo_n;
   logic [WIDTH:0]   w_sum, w_shift, w_diff;

   // Operand conditioning at start: magnitudes and sign bookkeeping for signed divide
   always_comb begin
      w_is_mul = (i_op == ALU_MUL) || (i_op == ALU_MULHU);
      w_signed = (i_op == ALU_DIV) || (i_op == ALU_REM);
      w_a_neg  = w_signed && i_a[WIDTH-1];
      w_b_neg  = w_signed && i_b[WIDTH-1];
      w_a_mag  = w_a_neg ? ({WIDTH{1'b0}} - i_a) : i_a;
      w_b_mag  = w_b_neg ? ({WIDTH{1'b0}} - i_b) : i_b;
   end

   // One iteration step; r_hi/r_lo are the 2*WIDTH accumulator or remainder/quotient pair
   always_comb begin
      w_sum   = {1'b0, r_hi} + ({1'b0, r_d} & {(WIDTH+1){r_lo[0]}});
      w_shift = {r_hi, r_lo[WIDTH-1]};
      w_diff  = w_shift - {1'b0, r_d};
      w_qbit  = ~w_diff[WIDTH];
      if ((r_op == ALU_MUL) || (r_op == ALU_MULHU)) begin
         w_hi_n = w_sum[WIDTH:1];
         w_lo_n = {w_sum[0], r_lo[WIDTH-1:1]};
      end else begin
         w_hi_n = w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
         w_lo_n = {r_lo[WIDTH-2:0], w_qbit};
      end
   end

   // Result selection with sign fix-up; a zero divisor forces an all-ones quotient
   always_comb begin
      o_last = r_run && (r_cnt == LAST_CNT);
      case (r_op)
         ALU_MUL:           o_result = w_lo_n;
         ALU_MULHU:         o_result = w_hi_n;
         ALU_DIVU, ALU_DIV: o_result = r_dz ? {WIDTH{1'b1}}
                                            : (r_neg_q ? ({WIDTH{1'b0}} - w_lo_n) : w_lo_n);
         ALU_REMU, ALU_REM: o_result = r_neg_r ? ({WIDTH{1'b0}} - w_hi_n) : w_hi_n;
         default:           o_result = {WIDTH{1'b0}};
      endcase
   end

   // Load, iterate and count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_run   <= 1'b0;
         r_cnt   <= {(SHW+1){1'b0}};
         r_op    <= 4'b0000;
         r_hi    <= {WIDTH{1'b0}};
         r_lo    <= {WIDTH{1'b0}};
         r_d     <= {WIDTH{1'b0}};
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_dz    <= 1'b0;
      end else if (i_flush) begin
         r_run <= 1'b0;
         r_cnt <= {(SHW+1){1'b0}};
      end else if (i_start) begin
         r_run   <= 1'b1;
         r_cnt   <= {(SHW+1){1'b0}};
         r_op    <= i_op;
         r_hi    <= {WIDTH{1'b0}};
         r_lo    <= w_is_mul ? i_b : w_a_mag;
         r_d     <= w_is_mul ? i_a : w_b_mag;
         r_neg_q <= w_a_neg ^ w_b_neg;
         r_neg_r <= w_a_neg;
         r_dz    <= (i_b == {WIDTH{1'b0}});
      end else if (r_run) begin
         r_hi <= w_hi_n;
         r_lo <= w_lo_n;
         if (o_last) begin
            r_run <= 1'b0;
            r_cnt <= {(SHW+1){1'b0}};
         end else begin
            r_cnt <= r_cnt + {{SHW{1'b0}}, 1'b1};
         end
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops computed combinationally and registered,
// multiply/divide/remainder delegated to alu_iter_core while issue is stalled.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             zero,
   output logic             busy
);

   localparam int SHW = $clog2(WIDTH);

   state_t           r_state, w_state_n;
   logic [WIDTH-1:0] r_y, w_alu, w_iter_y;
   logic             r_zero, r_out_valid, r_busy;
   logic             w_held, w_accept, w_op_iter, w_start, w_last;
   logic [SHW-1:0]   w_shamt;

   // Single-cycle datapath
   always_comb begin
      w_shamt = b[SHW-1:0];
      case (op)
         ALU_AND:  w_alu = a & b;
         ALU_OR:   w_alu = a | b;
         ALU_XOR:  w_alu = a ^ b;
         ALU_ADD:  w_alu = a + b;
         ALU_SUB:  w_alu = a - b;
         ALU_SLL:  w_alu = a << w_shamt;
         ALU_SRL:  w_alu = a >> w_shamt;
         ALU_SRA:  w_alu = $unsigned($signed(a) >>> w_shamt);
         ALU_SLT:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         ALU_SLTU: w_alu = {{(WIDTH-1){1'b0}}, (a < b)};
         default:  w_alu = {WIDTH{1'b0}};
      endcase
   end

   // Handshake and next-state; flush wins over any accept in the same cycle
   always_comb begin
      w_held    = (r_state == ONE) || (r_state == DONE);
      in_ready  = (r_state == IDLE) || (w_held && out_ready);
      w_op_iter = is_iter(op);
      w_accept  = in_valid && in_ready && !flush;
      w_start   = w_accept && w_op_iter;
      w_state_n = r_state;
      if (flush) begin
         w_state_n = IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) w_state_n = w_op_iter ? ITER : ONE;
               else          w_state_n = IDLE;
            end
            ONE, DONE: begin
               if (w_accept)       w_state_n = w_op_iter ? ITER : ONE;
               else if (out_ready) w_state_n = IDLE;
               else                w_state_n = r_state;
            end
            ITER: begin
               if (w_last) w_state_n = DONE;
               else        w_state_n = ITER;
            end
            default: w_state_n = IDLE;
         endcase
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_n;
   end

   // Registered result and status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_y         <= {WIDTH{1'b0}};
         r_zero      <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_out_valid <= (w_state_n == ONE) || (w_state_n == DONE);
         r_busy      <= (w_state_n == ITER);
         if (w_accept && !w_op_iter) begin
            r_y    <= w_alu;
            r_zero <= (w_alu == {WIDTH{1'b0}});
         end else if (!flush && (r_state == ITER) && w_last) begin
            r_y    <= w_iter_y;
            r_zero <= (w_iter_y == {WIDTH{1'b0}});
         end
      end
   end

   alu_iter_core #(.WIDTH(WIDTH)) u_iter (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_flush  (flush),
      .i_start  (w_start),
      .i_op     (op),
      .i_a      (a),
      .i_b      (b),
      .o_last   (w_last),
      .o_result (w_iter_y)
   );

   assign y         = r_y;
   assign zero      = r_zero;
   assign out_valid = r_out_valid;
   assign busy      = r_busy;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=64: vector table plus handshake corner sequences.
module tb_alu_seq;

   localparam int W  = 64;
   localparam int NV = 25;

   typedef struct {
      logic [3:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] y;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst_n, flush, in_valid, out_ready;
   logic [3:0]   op;
   logic [W-1:0] a, b, y;
   logic         in_ready, out_valid, zero, busy;

   int checks = 0;
   int errors = 0;
   vec_t tv [NV];

   always #5 clk = ~clk;

   alu_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
      .zero      (zero),
      .busy      (busy)
   );

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic bit iter_op(input logic [3:0] o);
      return (o == 4'b1001) || (o == 4'b1011) || (o[3:2] == 2'b11);
   endfunction

   task automatic issue(input logic [3:0] o, input logic [W-1:0] xa, input logic [W-1:0] xb);
      @(negedge clk);
      op = o; a = xa; b = xb; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   // lat counts edges from the accept edge (inclusive) until out_valid is seen
   task automatic wait_result(output int lat, output int bcnt);
      lat = 1; bcnt = 0;
      @(negedge clk);
      while (!out_valid && lat < 200) begin
         if (busy) bcnt++;
         @(negedge clk);
         lat++;
      end
      if (!out_valid) chk("result_timeout", {63'd0, out_valid}, 64'd1);
   endtask

   task automatic drain();
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   task automatic watch_quiet(input string nm);
      int seen = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk(nm, 64'(seen), 64'd0);
   endtask

   task automatic add_after(input string nm);
      int lat, bcnt;
      issue(4'b0010, 64'd2, 64'd3);
      wait_result(lat, bcnt);
      chk({nm, "_y"}, y, 64'd5);
      chk({nm, "_lat"}, 64'(lat), 64'd1);
      drain();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat, bcnt;
      tv[0]  = '{4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0};
      tv[1]  = '{4'b0100, 64'hFFFF_FFFF_FFFF_FFFB, 64'd3, 64'd1};
      tv[2]  = '{4'b0101, 64'hFFFF_FFFF_FFFF_FFFB, 64'd3, 64'd0};
      tv[3]  = '{4'b1010, 64'h8000_0000_0000_0000, 64'h43, 64'hF000_0000_0000_0000};
      tv[4]  = '{4'b1011, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE};
      tv[5]  = '{4'b1110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD};
      tv[6]  = '{4'b1111, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF};
      tv[7]  = '{4'b1100, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF};
      tv[8]  = '{4'b1111, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0};
      tv[9]  = '{4'b0110, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE};
      tv[10] = '{4'b0000, 64'hFF00_FF00_FF00_FF00, 64'h0FF0_0FF0_0FF0_0FF0, 64'h0F00_0F00_0F00_0F00};
      tv[11] = '{4'b0001, 64'hFF00_FF00_FF00_FF00, 64'h0FF0_0FF0_0FF0_0FF0, 64'hFFF0_FFF0_FFF0_FFF0};
      tv[12] = '{4'b0111, 64'hFF00_FF00_FF00_FF00, 64'h0FF0_0FF0_0FF0_0FF0, 64'hF0F0_F0F0_F0F0_F0F0};
      tv[13] = '{4'b0011, 64'd1, 64'h45, 64'h20};
      tv[14] = '{4'b1000, 64'h8000_0000_0000_0000, 64'd4, 64'h0800_0000_0000_0000};
      tv[15] = '{4'b1001, 64'h1_0000_0001, 64'd3, 64'h3_0000_0003};
      tv[16] = '{4'b1001, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1};
      tv[17] = '{4'b1110, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000};
      tv[18] = '{4'b1100, 64'd100, 64'd7, 64'd14};
      tv[19] = '{4'b1101, 64'd100, 64'd7, 64'd2};
      tv[20] = '{4'b1110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF};
      tv[21] = '{4'b1111, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 64'hFFFF_FFFF_FFFF_FFF9};
      tv[22] = '{4'b1011, 64'h1_0000_0000, 64'h1_0000_0000, 64'd1};
      tv[23] = '{4'b1110, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD};
      tv[24] = '{4'b1111, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1};

      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      op = 4'b0000; a = '0; b = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_y", y, 64'd0);
      chk("rst_zero", {63'd0, zero}, 64'd1);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      rst_n = 1'b1;

      for (int i = 0; i < NV; i++) begin
         issue(tv[i].op, tv[i].a, tv[i].b);
         wait_result(lat, bcnt);
         chk($sformatf("vec%0d_y", i), y, tv[i].y);
         chk($sformatf("vec%0d_zero", i), {63'd0, zero}, {63'd0, (tv[i].y == 64'd0)});
         chk($sformatf("vec%0d_lat", i), 64'(lat), iter_op(tv[i].op) ? 64'd65 : 64'd1);
         chk($sformatf("vec%0d_busy", i), 64'(bcnt), iter_op(tv[i].op) ? 64'd64 : 64'd0);
         drain();
      end

      // Backpressure, then drain and accept on the same edge
      issue(4'b0010, 64'd2, 64'd3);
      wait_result(lat, bcnt);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_y", y, 64'd5);
         chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
         chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
      end
      out_ready = 1'b1; in_valid = 1'b1; op = 4'b0010; a = 64'd10; b = 64'd20;
      #1 chk("bp_ready_on_drain", {63'd0, in_ready}, 64'd1);
      @(posedge clk);
      #1 in_valid = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      chk("bp_next_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_next_y", y, 64'd30);
      drain();

      // Flush while a result is held, with a simultaneous in_valid that must be dropped
      issue(4'b0010, 64'd1, 64'd1);
      wait_result(lat, bcnt);
      flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; op = 4'b0010; a = 64'd4; b = 64'd4;
      @(posedge clk);
      #1 flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      chk("fh_out_valid", {63'd0, out_valid}, 64'd0);
      chk("fh_idle", {63'd0, in_ready}, 64'd1);
      chk("fh_busy", {63'd0, busy}, 64'd0);

      // Flush at iteration 20 of a DIV
      issue(4'b1110, 64'd100, 64'd7);
      repeat (20) @(posedge clk);
      @(negedge clk);
      chk("fl_busy_before", {63'd0, busy}, 64'd1);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      chk("fl_out_valid", {63'd0, out_valid}, 64'd0);
      chk("fl_busy", {63'd0, busy}, 64'd0);
      chk("fl_idle", {63'd0, in_ready}, 64'd1);
      watch_quiet("fl_quiet");
      add_after("fl_add");

      // Reset pulse during ITER
      issue(4'b1011, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rs_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rs_busy", {63'd0, busy}, 64'd0);
      chk("rs_in_ready", {63'd0, in_ready}, 64'd1);
      chk("rs_y", y, 64'd0);
      chk("rs_zero", {63'd0, zero}, 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      watch_quiet("rs_quiet");
      add_after("rs_add");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the single-cycle ALU. It executes the existing single-cycle operation set plus iterative multiply, divide and remainder. Results are registered and returned over a valid/ready interface. It sits between the decode/operand-read stage and write-back, and stalls issue while an iterative operation is in progress.

## Interface
- WIDTH, 64, operand/result width in bits (≥ 8, power of two)
- SHW, $clog2(WIDTH), shift-amount width (derived; not overridden)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous abort of any accepted/in-flight op
- in_valid  in  1  operands/op presented
- in_ready  out  1  block can accept
- op  in  4  operation code
- a, b  in  WIDTH each  operands
- out_valid  out  1  result held
- out_ready  in  1  consumer takes result
- y  out  WIDTH  result
- zero  out  1  y == 0, registered with y
- busy  out  1  iterative op in progress

## Operation
- Op codes:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB
  - 0011 SLL
  - 0100 SLT (signed, two's complement)
  - 0101 SLTU
  - 0111 XOR
  - 1000 SRL
  - 1010 SRA
  - 1001 MUL (low WIDTH of a*b)
  - 1011 MULHU (high WIDTH of unsigned a*b)
  - 1100 DIVU
  - 1101 REMU
  - 1110 DIV
  - 1111 REM
- All 16 codes are defined; there is no illegal-op path.
- Shifts use b[SHW-1:0] only. SRA replicates a[WIDTH-1].
- ADD/SUB wrap modulo 2^WIDTH. SLT/SLTU return 1 or 0, zero-extended.
- FSM states:
  - IDLE → ONE on accepting a single-cycle op.
  - IDLE → ITER on accepting ops 1001/1011/11xx.
  - ITER → DONE after WIDTH iterations.
  - ONE/DONE → IDLE on out_valid && out_ready.
- ONE and DONE are both "result held" states.
- MUL/MULHU: shift-add, one bit of b per cycle, 2·WIDTH accumulator.
- DIV/REM:
  - Restoring division on magnitudes, one quotient bit per cycle.
  - Quotient sign = a_sign ^ b_sign; remainder takes the sign of a.
- Divide by zero: quotient = all ones, remainder = a. Still takes the full WIDTH iterations.
- Signed overflow (DIV of most-negative by −1): quotient = most-negative, remainder = 0.
- y, zero and out_valid hold stable while out_valid && !out_ready.

## Timing
- Reset values: in_ready=1, out_valid=0, y=0, zero=1, busy=0, state=IDLE, iteration counter=0.
- Accept on the edge where in_valid && in_ready.
- in_ready = (state==IDLE) || (result held && out_ready). This gives back-to-back issue on the same edge a result drains.
- Single-cycle op accepted at edge t: out_valid=1 from edge t+1.
- Iterative op accepted at edge t: busy=1 from t+1 through t+WIDTH; out_valid=1 from edge t+WIDTH+1.
- Iteration counter is SHW+1 bits and counts 0..WIDTH−1.
- flush: on the next edge, state=IDLE, out_valid=0, busy=0. A result being held is discarded. flush overrides a simultaneous accept, so in_valid in that cycle is dropped.
- rst_n low mid-operation: immediate return to reset values. No partial result is ever presented.
- Simultaneous drain and accept: the new op is captured and the old result is released on the same edge.

## Structure
- Shared package alu_pkg:
  - op-code localparams (ALU_AND … ALU_REM)
  - state enum (IDLE, ONE, ITER, DONE)
  - helper is_iter(op)
- The single-cycle datapath is combinational inside alu_seq.
- Sub-module alu_iter_core holds the shift-add/restoring datapath, counter and sign fix-up. Its handshake is start/done.

## Test plan
- WIDTH=64: ADD a=0xFFFF_FFFF_FFFF_FFFF, b=1 → y=0, zero=1, out_valid one cycle after accept.
- SLT a=−5 (0xFFFF_FFFF_FFFF_FFFB), b=3 → y=1. SLTU with the same operands → y=0. SRA a=0x8000_0000_0000_0000, b=0x43 (shift 3) → y=0xF000_0000_0000_0000.
- MULHU a=b=0xFFFF_FFFF_FFFF_FFFF → y=0xFFFF_FFFF_FFFF_FFFE, out_valid exactly 65 cycles after accept, busy high for 64 cycles.
- DIV a=−7, b=2 → y=−3; REM same → y=−1. DIVU b=0 → y=all ones. REM of most-negative by −1 → y=0.
- Backpressure: hold out_ready=0 for 10 cycles after a result → y/out_valid stable and in_ready=0. Raise out_ready with in_valid high → the next op is accepted on the same edge.
- Assert flush at iteration 20 of a DIV, and separately pulse rst_n low during ITER. Each time: no out_valid, state IDLE next cycle, and a following ADD 2+3 returns 5.
